// File: rtl/cache_mem_interface.sv
// Cache-line memory sequencer: turns one line read/write request into a burst of
// BUS_WIDTH beats over a REQ/READY RAM bus, with a per-beat wait timeout.
module cache_mem_interface #(
   parameter int LINE_WIDTH      = 128,
   parameter int BUS_WIDTH       = 32,
   parameter int LINE_ADDR_WIDTH = 8,
   parameter int TIMEOUT         = 255,
   localparam int BEATS          = LINE_WIDTH / BUS_WIDTH,
   localparam int BEAT_W         = $clog2(BEATS),
   localparam int RAM_ADDR_W     = LINE_ADDR_WIDTH + BEAT_W,
   localparam int TMO_W          = $clog2(TIMEOUT + 1)
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_sig_ram_rd,
   input  logic                       i_sig_ram_wr,
   input  logic [LINE_ADDR_WIDTH-1:0] i_line_addr,
   input  logic [LINE_WIDTH-1:0]      i_mi_in_data,
   output logic [LINE_WIDTH-1:0]      o_mi_out_data,
   output logic                       o_mi_sig_ram_ack,
   output logic                       o_mi_sig_ram_err,
   output logic                       o_ram_req,
   output logic                       o_ram_we,
   output logic [RAM_ADDR_W-1:0]      o_ram_addr,
   output logic [BUS_WIDTH-1:0]       o_ram_wdata,
   input  logic [BUS_WIDTH-1:0]       i_ram_rdata,
   input  logic                       i_ram_ready
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_ACK,
      S_RELEASE
   } state_t;

   state_t                     r_state, w_state_next;
   logic [LINE_ADDR_WIDTH-1:0] r_line_addr, w_line_addr_next;
   logic [LINE_WIDTH-1:0]      r_wline, w_wline_next;
   logic [LINE_WIDTH-1:0]      r_rbuf, w_rbuf_next;
   logic [LINE_WIDTH-1:0]      r_out, w_out_next;
   logic [BEAT_W-1:0]          r_beat, w_beat_next;
   logic [TMO_W-1:0]           r_tmo, w_tmo_next;
   logic                       r_req, w_req_next;
   logic                       r_we, w_we_next;
   logic [RAM_ADDR_W-1:0]      r_ram_addr, w_ram_addr_next;
   logic [BUS_WIDTH-1:0]       r_wdata, w_wdata_next;
   logic                       r_ack, w_ack_next;
   logic                       r_err, w_err_next;

   logic [BEAT_W-1:0]          w_beat_inc;
   logic                       w_last_beat;
   logic                       w_timed_out;
   logic [BUS_WIDTH-1:0]       w_wslice [BEATS];

   for (genvar gi = 0; gi < BEATS; gi++) begin : g_wslice
      assign w_wslice[gi] = r_wline[gi*BUS_WIDTH +: BUS_WIDTH];
   end

   assign w_beat_inc  = r_beat + 1'b1;
   assign w_last_beat = (r_beat == BEAT_W'(BEATS - 1));
   assign w_timed_out = (r_tmo == TMO_W'(TIMEOUT - 1));

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= S_IDLE;
         r_line_addr <= '0;
         r_wline     <= '0;
         r_rbuf      <= '0;
         r_out       <= '0;
         r_beat      <= '0;
         r_tmo       <= '0;
         r_req       <= 1'b0;
         r_we        <= 1'b0;
         r_ram_addr  <= '0;
         r_wdata     <= '0;
         r_ack       <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_line_addr <= w_line_addr_next;
         r_wline     <= w_wline_next;
         r_rbuf      <= w_rbuf_next;
         r_out       <= w_out_next;
         r_beat      <= w_beat_next;
         r_tmo       <= w_tmo_next;
         r_req       <= w_req_next;
         r_we        <= w_we_next;
         r_ram_addr  <= w_ram_addr_next;
         r_wdata     <= w_wdata_next;
         r_ack       <= w_ack_next;
         r_err       <= w_err_next;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_line_addr_next = r_line_addr;
      w_wline_next     = r_wline;
      w_rbuf_next      = r_rbuf;
      w_out_next       = r_out;
      w_beat_next      = r_beat;
      w_tmo_next       = r_tmo;
      w_req_next       = r_req;
      w_we_next        = r_we;
      w_ram_addr_next  = r_ram_addr;
      w_wdata_next     = r_wdata;
      w_ack_next       = 1'b0;
      w_err_next       = 1'b0;

      case (r_state)
         S_IDLE: begin
            // Write wins when both requests are raised together.
            if (i_sig_ram_wr || i_sig_ram_rd) begin
               w_line_addr_next = i_line_addr;
               w_beat_next      = '0;
               w_tmo_next       = '0;
               w_req_next       = 1'b1;
               w_we_next        = i_sig_ram_wr;
               w_ram_addr_next  = {i_line_addr, {BEAT_W{1'b0}}};
               w_state_next     = i_sig_ram_wr ? S_WRITE : S_READ;
               if (i_sig_ram_wr) begin
                  w_wline_next = i_mi_in_data;
                  w_wdata_next = i_mi_in_data[BUS_WIDTH-1:0];
               end
            end
         end

         S_WRITE, S_READ: begin
            if (i_ram_ready) begin
               if (r_state == S_READ) begin
                  w_rbuf_next[r_beat*BUS_WIDTH +: BUS_WIDTH] = i_ram_rdata;
               end
               w_tmo_next = '0;
               if (w_last_beat) begin
                  w_req_next   = 1'b0;
                  w_we_next    = 1'b0;
                  w_ack_next   = 1'b1;
                  w_state_next = S_ACK;
                  // Includes the final beat captured at this same edge.
                  if (r_state == S_READ) begin
                     w_out_next = w_rbuf_next;
                  end
               end else begin
                  w_beat_next     = w_beat_inc;
                  w_ram_addr_next = {r_line_addr, w_beat_inc};
                  w_wdata_next    = w_wslice[w_beat_inc];
               end
            end else if (w_timed_out) begin
               w_req_next   = 1'b0;
               w_we_next    = 1'b0;
               w_ack_next   = 1'b1;
               w_err_next   = 1'b1;
               w_state_next = S_ACK;
            end else begin
               w_tmo_next = r_tmo + 1'b1;
            end
         end

         S_ACK: begin
            w_state_next = S_RELEASE;
         end

         S_RELEASE: begin
            // Hold off until the control side has dropped its request.
            if (!i_sig_ram_rd && !i_sig_ram_wr) begin
               w_state_next = S_IDLE;
            end
         end

         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   assign o_mi_out_data    = r_out;
   assign o_mi_sig_ram_ack = r_ack;
   assign o_mi_sig_ram_err = r_err;
   assign o_ram_req        = r_req;
   assign o_ram_we         = r_we;
   assign o_ram_addr       = r_ram_addr;
   assign o_ram_wdata      = r_wdata;

endmodule

// File: tb/tb_cache_mem_interface.sv
// Bench for cache_mem_interface: a vector table of line transfers against a RAM
// responder, with beat and ACK scoreboards plus hand-written reset/hold sequences.
module tb_cache_mem_interface;

   localparam int LW  = 128;
   localparam int BW  = 32;
   localparam int AW  = 8;
   localparam int TMO = 4;
   localparam int RAW = 10;

   logic          clk = 1'b0;
   logic          reset;
   logic          rd, wr;
   logic [AW-1:0] line_addr;
   logic [LW-1:0] in_data;
   logic [LW-1:0] out_data;
   logic          ack, err, req, we;
   logic [RAW-1:0] ram_addr;
   logic [BW-1:0] wdata;
   logic [BW-1:0] rdata = '0;
   logic          ready = 1'b0;

   cache_mem_interface #(
      .LINE_WIDTH      (LW),
      .BUS_WIDTH       (BW),
      .LINE_ADDR_WIDTH (AW),
      .TIMEOUT         (TMO)
   ) dut (
      .i_clk            (clk),
      .i_reset          (reset),
      .i_sig_ram_rd     (rd),
      .i_sig_ram_wr     (wr),
      .i_line_addr      (line_addr),
      .i_mi_in_data     (in_data),
      .o_mi_out_data    (out_data),
      .o_mi_sig_ram_ack (ack),
      .o_mi_sig_ram_err (err),
      .o_ram_req        (req),
      .o_ram_we         (we),
      .o_ram_addr       (ram_addr),
      .o_ram_wdata      (wdata),
      .i_ram_rdata      (rdata),
      .i_ram_ready      (ready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic           we;
      logic [RAW-1:0] addr;
      logic [BW-1:0]  wdata;
   } beat_t;

   typedef struct {
      logic          err;
      logic [LW-1:0] out;
   } ack_t;

   typedef struct {
      string         name;
      logic          rd;
      logic          wr;
      logic [AW-1:0] addr;
      logic [LW-1:0] data;
      int            stall_beat;
      int            stall_cycles;
      logic          exp_err;
      int            exp_lat;
      int            hold_after;
   } vec_t;

   beat_t beat_q[$];
   ack_t  ack_q[$];
   logic [BW-1:0] mem [0:1023];
   logic [LW-1:0] model_out = '0;
   logic [RAW-1:0] stall_addr = '0;
   int stall_cycles = 0;
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // RAM responder and beat scoreboard
   logic  in_beat = 1'b0;
   int    wait_left = 0;
   beat_t held;
   beat_t mon_beat;
   always @(negedge clk) begin
      if (!req) begin
         in_beat = 1'b0;
         ready   = 1'b0;
      end else begin
         if (!in_beat) begin
            in_beat    = 1'b1;
            held.we    = we;
            held.addr  = ram_addr;
            held.wdata = wdata;
            wait_left  = (ram_addr == stall_addr) ? stall_cycles : 0;
         end else begin
            chk("beat_stable", {we, ram_addr, wdata}, {held.we, held.addr, held.wdata});
         end
         rdata = mem[ram_addr];
         if (wait_left == 0) begin
            ready   = 1'b1;
            in_beat = 1'b0;
            if (beat_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got addr %h we %b, expected no beat", ram_addr, we);
            end else begin
               mon_beat = beat_q.pop_front();
               chk("beat_we", we, mon_beat.we);
               chk("beat_addr", ram_addr, mon_beat.addr);
               if (mon_beat.we) chk("beat_wdata", wdata, mon_beat.wdata);
            end
         end else begin
            ready = 1'b0;
            wait_left--;
         end
      end
   end

   // ACK scoreboard
   ack_t mon_ack;
   always @(negedge clk) begin
      if (ack) begin
         if (ack_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: got ack=1, expected none");
         end else begin
            mon_ack = ack_q.pop_front();
            chk("ack_err", err, mon_ack.err);
            chk("ack_out", out_data, mon_ack.out);
         end
      end else if (err) begin
         checks++;
         errors++;
         $display("FAIL err_without_ack: got err=1 ack=0, expected err only with ack");
      end
   end

   function automatic vec_t mk(input string n, input logic r, input logic w, input logic [AW-1:0] a,
                               input logic [LW-1:0] d, input int sb, input int sc, input logic e,
                               input int lat, input int hold);
      vec_t v;
      v.name = n; v.rd = r; v.wr = w; v.addr = a; v.data = d;
      v.stall_beat = sb; v.stall_cycles = sc; v.exp_err = e; v.exp_lat = lat; v.hold_after = hold;
      return v;
   endfunction

   task automatic push_line(input logic w, input logic [AW-1:0] a, input logic [LW-1:0] d, input int nbeats);
      beat_t b;
      for (int k = 0; k < nbeats; k++) begin
         b.we    = w;
         b.addr  = {a, 2'(k)};
         b.wdata = d[k*BW +: BW];
         beat_q.push_back(b);
      end
   endtask

   function automatic logic [LW-1:0] mem_line(input logic [AW-1:0] a);
      logic [LW-1:0] l;
      for (int k = 0; k < 4; k++) l[k*BW +: BW] = mem[{a, 2'(k)}];
      return l;
   endfunction

   task automatic wait_ack(input string name, input int t0, input int exp_lat);
      int n = 0;
      @(negedge clk);
      while (!ack && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!ack) begin
         checks++;
         errors++;
         $display("FAIL %s_ack_timeout: got no ack in 50 cycles, expected ack", name);
      end else begin
         chk({name, "_latency"}, cyc - t0, exp_lat);
      end
   endtask

   task automatic run_vec(input vec_t v);
      ack_t a;
      int   t0;
      @(negedge clk);
      line_addr    = v.addr;
      in_data      = v.data;
      rd           = v.rd;
      wr           = v.wr;
      stall_addr   = {v.addr, 2'(v.stall_beat)};
      stall_cycles = v.stall_cycles;
      push_line(v.wr, v.addr, v.data, v.exp_err ? v.stall_beat : 4);
      if (!v.wr && !v.exp_err) model_out = mem_line(v.addr);
      a.err = v.exp_err;
      a.out = model_out;
      ack_q.push_back(a);
      @(posedge clk);
      t0 = cyc;
      wait_ack(v.name, t0, v.exp_lat);
      for (int h = 0; h < v.hold_after; h++) begin
         @(negedge clk);
         chk({v.name, "_hold_noreq"}, req, 1'b0);
      end
      rd = 1'b0;
      wr = 1'b0;
      @(negedge clk);
      chk({v.name, "_beats_left"}, beat_q.size(), 0);
      chk({v.name, "_acks_left"}, ack_q.size(), 0);
      $display("vector %s: addr %h rd %b wr %b out %h", v.name, v.addr, v.rd, v.wr, out_data);
   endtask

   vec_t vecs [8];

   initial begin
      int   t0;
      int   n;
      ack_t a;

      for (int i = 0; i < 1024; i++) mem[i] = 32'h5A000000 | (32'(i) * 32'h00001001);
      mem[10'h0E8] = 32'h11111111;
      mem[10'h0E9] = 32'h22222222;
      mem[10'h0EA] = 32'h33333333;
      mem[10'h0EB] = 32'h44444444;

      vecs[0] = mk("rd_3a",        1, 0, 8'h3A, '0, 0, 0, 0, 5, 0);
      vecs[1] = mk("wr_05_stall",  0, 1, 8'h05, 128'hDDDDCCCC_BBBBAAAA_99998888_77776666, 1, 3, 0, 8, 0);
      vecs[2] = mk("rdwr_prio",    1, 1, 8'h7F, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 0, 0, 0, 5, 3);
      vecs[3] = mk("rd_timeout",   1, 0, 8'h10, '0, 2, 1000, 1, 7, 0);
      vecs[4] = mk("rd_c3_stall0", 1, 0, 8'hC3, '0, 0, 2, 0, 7, 0);
      vecs[5] = mk("wr_ff_last",   0, 1, 8'hFF, 128'hCAFEF00D_DEADBEEF_0BADC0DE_12345678, 3, 1, 0, 6, 0);
      vecs[6] = mk("rd_30_b2b",    1, 0, 8'h30, '0, 0, 0, 0, 5, 0);
      vecs[7] = mk("rd_31_b2b",    1, 0, 8'h31, '0, 0, 0, 0, 5, 0);

      reset = 1'b1; rd = 1'b0; wr = 1'b0; line_addr = '0; in_data = '0;
      repeat (2) @(negedge clk);
      chk("rst_req", req, 1'b0);
      chk("rst_we", we, 1'b0);
      chk("rst_addr", ram_addr, '0);
      chk("rst_wdata", wdata, '0);
      chk("rst_ack", ack, 1'b0);
      chk("rst_out", out_data, '0);
      reset = 1'b0;

      for (int i = 0; i < 8; i++) begin
         run_vec(vecs[i]);
         if (i == 0) chk("rd_3a_line", out_data, 128'h44444444_33333333_22222222_11111111);
      end

      // Asynchronous reset while beat 1 of a write is stalled
      @(negedge clk);
      line_addr = 8'h22; in_data = 128'hFEEDFACE_00C0FFEE_A5A5A5A5_5A5A5A5A; wr = 1'b1;
      stall_addr = 10'h089; stall_cycles = 5;
      push_line(1'b1, 8'h22, in_data, 4);
      n = 0;
      while (!(req && ram_addr == 10'h089) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rst_mid_found_beat1", {req, ram_addr}, {1'b1, 10'h089});
      #2;
      reset = 1'b1;
      wr = 1'b0;
      #1;
      chk("async_rst_req", req, 1'b0);
      chk("async_rst_we", we, 1'b0);
      chk("async_rst_addr", ram_addr, '0);
      chk("async_rst_wdata", wdata, '0);
      chk("async_rst_out", out_data, '0);
      chk("async_rst_beats_left", beat_q.size(), 3);
      beat_q.delete();
      model_out = '0;
      $display("async reset: req %b addr %h out %h", req, ram_addr, out_data);

      rd = 1'b1; line_addr = 8'h44; stall_cycles = 0;
      push_line(1'b0, 8'h44, '0, 4);
      model_out = mem_line(8'h44);
      a.err = 1'b0;
      a.out = model_out;
      ack_q.push_back(a);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      t0 = cyc;
      wait_ack("rst_fresh_rd", t0, 5);
      rd = 1'b0;
      @(negedge clk);
      chk("rst_fresh_beats_left", beat_q.size(), 0);
      chk("rst_fresh_acks_left", ack_q.size(), 0);
      $display("fresh read after reset: addr 44 out %h", out_data);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000, expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/cache_mem_interface.md
Name: cache_mem_interface

Overview:
Memory-interface sequencer between the cache control path and an external word-wide RAM bus.
- Accepts line-level read/write requests (SIG_RAM_RD / SIG_RAM_WR, held until acknowledged) for one cache line.
- Splits each request into a burst of BUS_WIDTH beats with a REQ/READY handshake.
- Assembles read lines and returns them on MI_OUT_DATA.
- Signals completion with a one-cycle MI_SIG_RAM_ACK.
- A per-beat timeout aborts hung transfers.

Parameters:
LINE_WIDTH, 128, cache line width in bits (= RAM-side line data size).
BUS_WIDTH, 32, external RAM data bus width; LINE_WIDTH must be an integer multiple.
LINE_ADDR_WIDTH, 8, line address width (tag+index bits).
TIMEOUT, 255, maximum cycles waiting for RAM_READY per beat before abort; must be ≥1.

Ports:
CLK  in  1  clock, rising edge.
RESET  in  1  asynchronous, active-high reset.
SIG_RAM_RD  in  1  line read request, level, held until MI_SIG_RAM_ACK.
SIG_RAM_WR  in  1  line write request, level, held until MI_SIG_RAM_ACK.
LINE_ADDR  in  LINE_ADDR_WIDTH  line address; sampled at request acceptance.
MI_IN_DATA  in  LINE_WIDTH  line to write; sampled at request acceptance.
MI_OUT_DATA  out  LINE_WIDTH  last line read from RAM.
MI_SIG_RAM_ACK  out  1  one-cycle completion pulse.
MI_SIG_RAM_ERR  out  1  one-cycle pulse coincident with ACK when the transfer timed out.
RAM_REQ  out  1  beat request to RAM.
RAM_WE  out  1  1 = write beat, 0 = read beat; valid while RAM_REQ.
RAM_ADDR  out  LINE_ADDR_WIDTH+log2(LINE_WIDTH/BUS_WIDTH)  word address {line_addr, beat}.
RAM_WDATA  out  BUS_WIDTH  write beat data.
RAM_RDATA  in  BUS_WIDTH  read beat data; valid when RAM_READY.
RAM_READY  in  1  RAM accepts/completes the current beat at this rising edge.

Behaviour:
- BEATS = LINE_WIDTH/BUS_WIDTH. Beat k carries line bits [k*BUS_WIDTH +: BUS_WIDTH]. Beats issue in ascending order, 0..BEATS-1.
- Reset (async, any state): state=IDLE; RAM_REQ, RAM_WE, RAM_ADDR, RAM_WDATA, MI_SIG_RAM_ACK, MI_SIG_RAM_ERR, MI_OUT_DATA, beat and timeout counters all 0. A burst in flight is abandoned; RAM_REQ drops immediately.
- IDLE:
  - On a rising edge with SIG_RAM_WR=1, latch LINE_ADDR and MI_IN_DATA, beat=0, go WRITE.
  - Else if SIG_RAM_RD=1, latch LINE_ADDR, beat=0, go READ.
  - RD and WR both high: write has priority; only the write is performed and acknowledged.
- WRITE / READ:
  - RAM_REQ=1 and RAM_WE=(WRITE), registered outputs, asserted the cycle after acceptance.
  - RAM_ADDR={latched addr, beat}; RAM_WDATA=latched beat slice.
  - Address, data and WE stay stable until RAM_READY is sampled high.
  - On RAM_READY=1: READ stores RAM_RDATA into the beat slice of an internal line buffer; beat increments; timeout counter clears. The next beat's REQ follows back-to-back with no idle cycle. After beat BEATS-1, RAM_REQ drops and the state goes to ACK.
  - On RAM_READY=0: the timeout counter increments. When it reaches TIMEOUT, RAM_REQ drops, err flag is set, and the state goes to ACK.
- ACK (one cycle): MI_SIG_RAM_ACK=1. MI_SIG_RAM_ERR=err flag.
  - Successful read: MI_OUT_DATA updates to the assembled line, visible in the same cycle as ACK.
  - Write, or timed-out read: MI_OUT_DATA is unchanged.
  - Next state: RELEASE.
- RELEASE: wait until SIG_RAM_RD=0 and SIG_RAM_WR=0, then go IDLE. This prevents re-issuing a request the control unit is still holding. The request may deassert in the ACK cycle itself; the minimum RELEASE stay is one cycle.
- Latency with RAM_READY tied high: accept edge → BEATS beat cycles → ACK cycle. Read of 4 beats: ACK is 5 cycles after the accept edge.
- Request inputs changing mid-burst are ignored; latched values are used throughout.
- MI_OUT_DATA holds its value across writes and timeouts.

Test Plan:
1. Defaults, RAM_READY=1, read LINE_ADDR=0x3A → RAM_ADDR 0x0E8,0x0E9,0x0EA,0x0EB on consecutive cycles with RAM_WE=0. RDATA 0x11111111..0x44444444 gives MI_OUT_DATA=0x44444444_33333333_22222222_11111111 with a one-cycle ACK 5 cycles after accept, ERR=0.
2. Write LINE_ADDR=0x05, MI_IN_DATA=0xDDDD_CCCC_BBBB_AAAA_..., RAM_READY low 3 cycles on beat 1 → WDATA/ADDR 0x015 held stable for 4 cycles; beats in order; single ACK; MI_OUT_DATA unchanged.
3. SIG_RAM_RD and SIG_RAM_WR both high → only write beats (RAM_WE=1) issued; one ACK. Requests held high 3 cycles after ACK → no new RAM_REQ until both drop.
4. TIMEOUT=4, RAM_READY stuck 0 on beat 2 of a read → RAM_REQ drops after 4 waiting cycles; ACK and ERR pulse together; MI_OUT_DATA keeps its previous value.
5. RESET asserted asynchronously mid-beat 1 of a write → RAM_REQ and all outputs 0 without waiting for a clock edge. After release with SIG_RAM_RD high, a fresh read starts at beat 0.
6. Back-to-back read requests (deassert during ACK, reassert 1 cycle later) → second burst starts correctly; no dropped or duplicated ACKs.
